// File: rtl/inst_sram_responder_pkg.sv
// Shared constants, state encoding and address-decode helper for the
// instruction-fetch responder and its array.
package inst_sram_responder_pkg;

   localparam logic [31:0] INST_NOP  = 32'h0340_0000;
   localparam logic [31:0] INST_BASE = 32'h1c00_0000;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned LAT_MIN    = 1;
   localparam int unsigned LAT_MAX    = 7;
   localparam int unsigned WAIT_W     = 3;

   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_WAIT = 2'd1,
      RSP_RESP = 2'd2
   } rsp_state_e;

   // Misaligned byte lane, or word index beyond the array once rebased.
   function automatic logic addr_fault(input logic [1:0]  byte_off,
                                       input logic [31:0] offset,
                                       input int unsigned addr_w);
      return (byte_off != 2'b00) || ((offset >> (addr_w + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/inst_sram_responder_sram_1r1w.sv
// One-read one-write synchronous array; the read register returns the
// pre-write contents when both ports hit the same word in one cycle.
module sram_1r1w
   import inst_sram_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned WIDTH      = DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents survive reset; only the read holding register is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction-fetch responder: accepts one fetch at a time, returns the
// addressed word (or a faulted NOP) as a single inst_ready pulse after LATENCY.
module inst_sram_responder
   import inst_sram_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter logic [31:0] BASE_ADDR  = INST_BASE,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           pc,
   input  logic                  pc_valid,
   output logic [31:0]           inst,
   output logic                  inst_ready,
   output logic                  err,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [31:0]           load_data,
   output logic [31:0]           resp_count
);

   if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("inst_sram_responder: LATENCY must lie in 1..7");
   end

   localparam logic [WAIT_W-1:0] WAIT_INIT =
      (LATENCY > 1) ? WAIT_W'(LATENCY - 2) : WAIT_W'(0);
   localparam logic HAS_WAIT = (LATENCY > 1);

   rsp_state_e            state;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [31:0]           offset_c;
   logic [ADDR_WIDTH-1:0] word_addr_c;
   logic                  fault_c;
   logic                  accept_c;
   logic [31:0]           rd_word;

   assign offset_c    = pc - BASE_ADDR;
   assign word_addr_c = ADDR_WIDTH'(offset_c >> 2);
   assign fault_c     = addr_fault(pc[1:0], offset_c, ADDR_WIDTH);
   assign accept_c    = (state == RSP_IDLE) && pc_valid;

   // Read happens in the acceptance cycle; the holding register keeps the
   // word stable until the next acceptance, so late preloads cannot leak in.
   sram_1r1w #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WIDTH      (DATA_WIDTH)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (accept_c && !fault_c),
      .rd_addr (word_addr_c),
      .rd_data (rd_word),
      .wr_en   (load_en),
      .wr_addr (load_addr),
      .wr_data (load_data)
   );

   // Both sources are flops updated only on acceptance.
   assign inst = err ? INST_NOP : rd_word;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RSP_IDLE;
         wait_cnt   <= '0;
         inst_ready <= 1'b0;
         err        <= 1'b0;
         resp_count <= '0;
      end else begin
         inst_ready <= 1'b0;
         case (state)
            RSP_IDLE: begin
               if (pc_valid) begin
                  err <= fault_c;
                  if (HAS_WAIT) begin
                     wait_cnt <= WAIT_INIT;
                     state    <= RSP_WAIT;
                  end else begin
                     inst_ready <= 1'b1;
                     state      <= RSP_RESP;
                  end
               end
            end
            RSP_WAIT: begin
               if (wait_cnt == '0) begin
                  inst_ready <= 1'b1;
                  state      <= RSP_RESP;
               end else begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end
            end
            RSP_RESP: begin
               resp_count <= resp_count + 32'd1;
               state      <= RSP_IDLE;
            end
            default: begin
               state <= RSP_IDLE;
            end
         endcase
      end
   end

endmodule
